// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the RV32I hazard/issue controller.
// Optional build macro HAZARD_BYPASS_EN is consumed by pipe_hazard_ctrl.
package pipe_hazard_ctrl_pkg;

    localparam int DEPTH_DEF     = 4;
    localparam int REG_IDX_W_DEF = 5;
    localparam int CNT_W_DEF     = 16;
    localparam int REG_X0        = 0;

    // Width of a reservation count able to hold 0..depth inclusive.
    function automatic int flush_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_rsv_queue.sv
// In-order circular reservation queue: {valid, rd} per slot, with
// per-entry source match vectors and head selection for the hazard logic.
module pipe_hazard_ctrl_rsv_queue
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int FW       = flush_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pop,
    input  logic                 alloc,
    input  logic [REG_IDX_W-1:0] alloc_rd,
    input  logic [FW-1:0]        flush_k,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [DEPTH-1:0]     match1,
    output logic [DEPTH-1:0]     match2,
    output logic [DEPTH-1:0]     head_sel,
    output logic [REG_IDX_W-1:0] head_rd,
    output logic [FW-1:0]        count,
    output logic                 full,
    output logic                 empty
);

    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     valid_next;
    logic [REG_IDX_W-1:0] rd_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_after;
    logic [PTR_W-1:0]     age;
    logic [FW-1:0]        count_next;

    // Retire, then allocate, then squash the flush_k youngest slots
    // (age 0 is the slot just below the post-allocation write pointer).
    always_comb begin
        wr_after   = wr_ptr + PTR_W'(alloc);
        valid_next = valid;
        age        = '0;
        if (pop)
            valid_next[rd_ptr] = 1'b0;
        if (alloc)
            valid_next[wr_ptr] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            age = wr_after - PTR_W'(i) - PTR_W'(1);
            if ({1'b0, age} < flush_k)
                valid_next[i] = 1'b0;
        end
        count_next = count - FW'(pop) + FW'(alloc) - flush_k;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            valid  <= valid_next;
            wr_ptr <= wr_after - PTR_W'(flush_k);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count_next;
            full   <= (count_next == FW'(DEPTH));
            empty  <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc)
            rd_mem[wr_ptr] <= alloc_rd;
    end

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = valid[i] && (rd_mem[i] == rs1);
            match2[i] = valid[i] && (rd_mem[i] == rs2);
        end
    end

    assign head_sel = DEPTH'(1) << rd_ptr;
    assign head_rd  = rd_mem[rd_ptr];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side scoreboard and issue control for the in-order RV32I pipeline.
// Define HAZARD_BYPASS_EN to let a dependent issue in its producer's writeback cycle.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    localparam int FW       = flush_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_wb_e,
    output logic                 id_stall,
    output logic                 id_issue,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [FW-1:0]        flush_n,
    output logic [FW-1:0]        inflight,
    output logic                 full,
    output logic                 empty,
    output logic                 err_wb,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic [DEPTH-1:0]     match1;
    logic [DEPTH-1:0]     match2;
    logic [DEPTH-1:0]     head_sel;
    logic [REG_IDX_W-1:0] head_rd;
    logic                 pop;
    logic                 alloc;
    logic [FW-1:0]        live;
    logic [FW-1:0]        flush_k;
    logic                 use1;
    logic                 use2;
    logic                 young1;
    logic                 young2;
    logic                 head1;
    logic                 head2;
    logic                 hit1;
    logic                 hit2;
    logic                 full_block;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pipe_hazard_ctrl_rsv_queue #(
        .DEPTH     (DEPTH),
        .REG_IDX_W (REG_IDX_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .pop      (pop),
        .alloc    (alloc),
        .alloc_rd (id_rd),
        .flush_k  (flush_k),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .match1   (match1),
        .match2   (match2),
        .head_sel (head_sel),
        .head_rd  (head_rd),
        .count    (inflight),
        .full     (full),
        .empty    (empty)
    );

    // x0 is never a real dependency, so rd=0 reservations can never match.
    assign use1   = id_use_rs1 && (id_rs1 != REG_IDX_W'(REG_X0));
    assign use2   = id_use_rs2 && (id_rs2 != REG_IDX_W'(REG_X0));
    assign young1 = |(match1 & ~head_sel);
    assign young2 = |(match2 & ~head_sel);
    assign head1  = |(match1 & head_sel);
    assign head2  = |(match2 & head_sel);
    assign pop    = wb_valid && !empty;

`ifdef HAZARD_BYPASS_EN
    logic head_retiring;
    assign head_retiring = pop && (head_rd == wb_rd);
    assign hit1          = use1 && (young1 || (head1 && !head_retiring));
    assign hit2          = use2 && (young2 || (head2 && !head_retiring));
    assign full_block    = full && !pop;
`else
    assign hit1          = use1 && (young1 || head1);
    assign hit2          = use2 && (young2 || head2);
    assign full_block    = full;
`endif

    assign id_stall = id_valid && (hit1 || hit2 || (id_wb_e && full_block));
    assign id_issue = id_valid && !id_stall;
    assign alloc    = id_issue && id_wb_e;

    // A same-cycle allocation is younger than the flushing branch, so it is counted.
    assign live    = inflight - FW'(pop) + FW'(alloc);
    assign flush_k = (flush_n < live) ? flush_n : live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_wb    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (wb_valid && (empty || (head_rd != wb_rd)))
                err_wb <= 1'b1;
            if (id_stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// against a queue-based reference model of the reservation rules.
module tb_pipe_hazard_ctrl;

    localparam int DEPTH = 4;
    localparam int RW    = 5;
    localparam int CW    = 16;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [RW-1:0] id_rd;
    logic          id_wb_e;
    logic          id_stall;
    logic          id_issue;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [FW-1:0] flush_n;
    logic [FW-1:0] inflight;
    logic          full;
    logic          empty;
    logic          err_wb;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        int stall;
        int issue;
        int inflight;
        int full;
        int empty;
        int err;
        int scnt;
    } exp_t;

    exp_t exp_q[$];
    int   mq[$];
    int   m_err;
    int   m_scnt;
    int   total = 0;
    int   bad   = 0;

    pipe_hazard_ctrl #(.DEPTH(DEPTH), .REG_IDX_W(RW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_wb_e    (id_wb_e),
        .id_stall   (id_stall),
        .id_issue   (id_issue),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush_n    (flush_n),
        .inflight   (inflight),
        .full       (full),
        .empty      (empty),
        .err_wb     (err_wb),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending source is any queued destination equal to it.
    function automatic bit src_hit(input int rs, input bit use_rs, input bit wv, input int wrd);
        int n = 0;
        if (!use_rs || rs == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == rs) n++;
`ifdef HAZARD_BYPASS_EN
        if (n == 1 && mq[0] == rs && wv && wrd == rs) return 1'b0;
`endif
        return n > 0;
    endfunction

    task automatic step(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                        input int rd, input bit wbe, input bit wv, input int wrd, input int fn,
                        output bit issued);
        exp_t e;
        bit   fb;
        bit   st;
        int   k;
        id_valid   = v;
        id_rs1     = RW'(r1);
        id_rs2     = RW'(r2);
        id_use_rs1 = u1;
        id_use_rs2 = u2;
        id_rd      = RW'(rd);
        id_wb_e    = wbe;
        wb_valid   = wv;
        wb_rd      = RW'(wrd);
        flush_n    = FW'(fn);
        fb = (mq.size() == DEPTH);
`ifdef HAZARD_BYPASS_EN
        if (wv) fb = 1'b0;
`endif
        st = v && (src_hit(r1, u1, wv, wrd) || src_hit(r2, u2, wv, wrd) || (wbe && fb));
        e.stall    = st;
        e.issue    = v && !st;
        e.inflight = mq.size();
        e.full     = (mq.size() == DEPTH);
        e.empty    = (mq.size() == 0);
        e.err      = m_err;
        e.scnt     = m_scnt;
        exp_q.push_back(e);
        if (wv) begin
            if (mq.size() == 0 || mq[0] != wrd) m_err = 1;
            if (mq.size() > 0) void'(mq.pop_front());
        end
        if (v && !st && wbe) mq.push_back(rd);
        k = (fn < mq.size()) ? fn : mq.size();
        repeat (k) void'(mq.pop_back());
        if (st && m_scnt < (1 << CW) - 1) m_scnt++;
        issued = v && !st;
        @(posedge clk);
        #1;
    endtask

    task automatic s(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                     input int rd, input bit wbe, input bit wv, input int wrd, input int fn);
        bit dummy;
        step(v, r1, r2, u1, u2, rd, wbe, wv, wrd, fn, dummy);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_wb_e = 1'b0;
        wb_valid = 1'b0; flush_n = '0;
        #1;
        chk({tag, "_inflight"}, inflight, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_err_wb"}, err_wb, 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
        chk({tag, "_id_stall"}, id_stall, 0);
        mq.delete();
        m_err = 0;
        m_scnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_stall", id_stall, e.stall);
                chk("id_issue", id_issue, e.issue);
                chk("inflight", inflight, e.inflight);
                chk("full", full, e.full);
                chk("empty", empty, e.empty);
                chk("err_wb", err_wb, e.err);
                chk("stall_cnt", stall_cnt, e.scnt);
            end
        end
    end

    initial begin
        bit iss;
        rst = 1'b1;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_wb_e = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush_n = '0;
        m_err = 0;
        m_scnt = 0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // addi x5 then add x6,x5,x1
        s(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        s(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        s(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        step(1, 5, 1, 1, 1, 6, 1, 1, 5, 0, iss);
        if (!iss) step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, iss);
        chk("raw_issued", iss, 1);
`ifdef HAZARD_BYPASS_EN
        chk("raw_stall_cnt", stall_cnt, 2);
`else
        chk("raw_stall_cnt", stall_cnt, 3);
`endif
        s(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        chk("raw_drained", empty, 1);

        // fill, blocked writer, non-writing store, retire frees a slot
        for (int r = 1; r <= 4; r++) s(1, 0, 0, 0, 0, r, 1, 0, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_inflight", inflight, 4);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, iss);
        chk("fill_writer_blocked", iss, 0);
        step(1, 8, 9, 1, 1, 0, 0, 0, 0, 0, iss);
        chk("fill_store_issues", iss, 1);
        step(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, iss);
        if (!iss) step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, iss);
        chk("fill_writer_accepted", iss, 1);
        chk("fill_inflight_after", inflight, 4);
        for (int r = 2; r <= 5; r++) s(0, 0, 0, 0, 0, 0, 0, 1, r, 0);

        // x0 source never hazards on a pending rd=0
        s(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 3, 0, 0, 0, 0, iss);
        chk("x0_no_stall", iss, 1);
        s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // flush the two youngest of x1,x2,x3
        for (int r = 1; r <= 3; r++) s(1, 0, 0, 0, 0, r, 1, 0, 0, 0);
        s(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        chk("flush_inflight", inflight, 1);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, iss);
        chk("flush_x3_free", iss, 1);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, iss);
        chk("flush_x1_pending", iss, 0);
        s(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        // retire + allocate + flush in one cycle
        s(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        s(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        s(1, 0, 0, 0, 0, 7, 1, 1, 1, 1);
        chk("combo_inflight", inflight, 1);
        s(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        chk("combo_head_x2", err_wb, 0);
        chk("combo_empty", empty, 1);

        // writeback order errors, sticky, then reset mid-stream
        s(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        chk("err_empty", err_wb, 1);
        s(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        s(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", err_wb, 1);
        s(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        do_reset("midreset");

        // random traffic
        for (int c = 0; c < 700; c++) begin
            bit v, wv;
            int wrd, fn;
            if (c == 350) do_reset("randreset");
            v   = ($urandom_range(0, 3) != 0);
            wv  = ($urandom_range(0, 9) < 3);
            wrd = (mq.size() > 0 && $urandom_range(0, 19) != 0) ? mq[0] : int'($urandom_range(0, 31));
            fn  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, DEPTH)) : 0;
            s(v, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
              wv, wrd, fn);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
